// File: rtl/rv_pkg.sv
// Shared constants for the RV32I execution datapath: ALU operation codes and
// the opcodes that affect immediate selection and write-back.
package rv_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I ALU. Shifts use only B[4:0]; unassigned operation codes
// produce zero so the Zero flag is well defined for them.
module rv_alu
    import rv_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALUControl,
    output logic [31:0] Result
);
    logic [4:0] shamt;
    assign shamt = B[4:0];

    always_comb begin
        Result = 32'd0;
        case (ALUControl)
            ALU_ADD:  Result = A + B;
            ALU_SUB:  Result = A - B;
            ALU_AND:  Result = A & B;
            ALU_OR:   Result = A | B;
            ALU_SLL:  Result = A << shamt;
            ALU_SLT:  Result = {31'd0, $signed(A) < $signed(B)};
            ALU_XOR:  Result = A ^ B;
            ALU_SRL:  Result = A >> shamt;
            ALU_SLTU: Result = {31'd0, A < B};
            ALU_SRA:  Result = $signed(A) >>> shamt;
            default:  Result = 32'd0;
        endcase
    end
endmodule

// File: rtl/rv_datapath.sv
// Single-cycle RV32I execution datapath: register file, immediate generator,
// ALU, word-addressed data memory and write-back mux. Control is external.
module rv_datapath
    import rv_pkg::*;
#(
    parameter int DMEM_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RegWrite,
    input  logic        ALUSrc,
    input  logic [3:0]  ALUControl,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        MemToReg,
    input  logic [31:0] Instruction,
    output logic        Sign,
    output logic        Zero
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [4:0]    rs1, rs2, rd;
    logic [6:0]    opcode;
    logic [31:0]   imm, rs1_data, rs2_data, alu_b, alu_res, load_data, wb_data;
    logic [AW-1:0] daddr;
    logic [31:0]   rf_q   [32];
    logic [31:0]   dmem_q [DMEM_WORDS];

    assign rs1    = Instruction[19:15];
    assign rs2    = Instruction[24:20];
    assign rd     = Instruction[11:7];
    assign opcode = Instruction[6:0];

    always_comb begin
        imm = {{20{Instruction[31]}}, Instruction[31:20]};
        if (opcode == OP_STORE)
            imm = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
        else if (opcode == OP_LUI)
            imm = {Instruction[31:12], 12'd0};
    end

    assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    assign alu_b    = ALUSrc ? imm : rs2_data;

    rv_alu u_alu (
        .A          (rs1_data),
        .B          (alu_b),
        .ALUControl (ALUControl),
        .Result     (alu_res)
    );

    assign Sign = alu_res[31];
    assign Zero = (alu_res == 32'd0);

    // Byte offset dropped, upper address bits wrap around the memory depth.
    assign daddr     = alu_res[AW+1:2];
    assign load_data = MemRead ? dmem_q[daddr] : 32'd0;

    always_comb begin
        wb_data = MemToReg ? load_data : alu_res;
        if (opcode == OP_LUI)
            wb_data = imm;
    end

    // Reset seeds xi = i so tests start from known, distinct register values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++)
                rf_q[i] <= 32'(i);
        end else if (RegWrite && rd != 5'd0) begin
            rf_q[rd] <= wb_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DMEM_WORDS; i++)
                dmem_q[i] <= 32'd0;
        end else if (MemWrite) begin
            dmem_q[daddr] <= rs2_data;
        end
    end
endmodule

// File: tb/tb_rv_datapath.sv
// Directed bench for rv_datapath: each instruction pushes its expected Sign/Zero
// into a scoreboard; a negedge monitor pops and compares. Register contents are
// observed by issuing "sub rs1 - imm" with RegWrite=0 and expecting Zero=1.
module tb_rv_datapath;
    import rv_pkg::*;

    typedef struct {
        string nm;
        logic  s;
        logic  z;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        RegWrite = 1'b0, ALUSrc = 1'b0, MemWrite = 1'b0, MemRead = 1'b0, MemToReg = 1'b0;
    logic [3:0]  ALUControl = 4'd0;
    logic [31:0] Instruction = 32'd0;
    logic        Sign, Zero;
    logic        chk_en = 1'b0;

    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;

    rv_datapath #(.DMEM_WORDS(64)) dut (
        .CLK(CLK), .RST_N(RST_N), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .ALUControl(ALUControl), .MemWrite(MemWrite), .MemRead(MemRead),
        .MemToReg(MemToReg), .Instruction(Instruction), .Sign(Sign), .Zero(Zero)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (chk_en) begin
            nchk++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL %0t no-expectation: flags S=%b Z=%b with empty scoreboard", $time, Sign, Zero);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (Sign !== e.s || Zero !== e.z) begin
                    nerr++;
                    $display("FAIL %s: got S=%b Z=%b, want S=%b Z=%b", e.nm, Sign, Zero, e.s, e.z);
                end
            end
        end
    end

    function automatic logic [31:0] r_t(int rd, int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), OP_R};
    endfunction

    function automatic logic [31:0] i_t(int rd, int rs1, int imm, logic [6:0] op);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'd0, 5'(rd), op};
    endfunction

    function automatic logic [31:0] s_t(int rs1, int rs2, int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'd0, im[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] u_t(int rd, int imm20);
        return {20'(imm20), 5'(rd), OP_LUI};
    endfunction

    task automatic step(input string nm, input logic [31:0] ins, input logic [3:0] op,
                        input logic src, input logic rw, input logic mw, input logic mr,
                        input logic m2r, input logic es, input logic ez);
        exp_t e;
        Instruction = ins; ALUControl = op; ALUSrc = src;
        RegWrite = rw; MemWrite = mw; MemRead = mr; MemToReg = m2r;
        e.nm = nm; e.s = es; e.z = ez;
        q.push_back(e);
        chk_en = 1'b1;
        @(posedge CLK);
        #1;
        chk_en = 1'b0;
        RegWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; MemToReg = 1'b0;
    endtask

    task automatic alu_r(input string nm, input int rd, input int rs1, input int rs2,
                         input logic [3:0] op, input logic rw, input logic es, input logic ez);
        step(nm, r_t(rd, rs1, rs2), op, 1'b0, rw, 1'b0, 1'b0, 1'b0, es, ez);
    endtask

    task automatic alu_i(input string nm, input int rd, input int rs1, input int imm,
                         input logic [3:0] op, input logic rw, input logic es, input logic ez);
        step(nm, i_t(rd, rs1, imm, OP_I), op, 1'b1, rw, 1'b0, 1'b0, 1'b0, es, ez);
    endtask

    task automatic chk_reg(input string nm, input int r, input int v);
        alu_i(nm, 0, r, v, ALU_SUB, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        // reset state
        chk_reg("rst_x0", 0, 0);
        chk_reg("rst_x2", 2, 2);
        chk_reg("rst_x3", 3, 3);
        chk_reg("rst_x31", 31, 31);

        // R-type arithmetic and compares
        alu_r("add_x1", 1, 3, 2, ALU_ADD, 1'b1, 1'b0, 1'b0);
        chk_reg("x1_eq5", 1, 5);
        alu_r("sub_x4", 4, 2, 3, ALU_SUB, 1'b1, 1'b1, 1'b0);
        chk_reg("x4_eq_m1", 4, -1);
        alu_r("slt_x8", 8, 4, 2, ALU_SLT, 1'b1, 1'b0, 1'b0);
        chk_reg("x8_eq1", 8, 1);
        alu_r("sltu_x11", 11, 4, 2, ALU_SLTU, 1'b1, 1'b0, 1'b1);
        chk_reg("x11_eq0", 11, 0);
        alu_r("sltu_rev", 0, 2, 4, ALU_SLTU, 1'b0, 1'b0, 1'b0);
        alu_r("sll_x7", 7, 2, 3, ALU_SLL, 1'b1, 1'b0, 1'b0);
        chk_reg("x7_eq16", 7, 16);

        // I-type
        alu_i("addi_x9", 9, 2, 20, ALU_ADD, 1'b1, 1'b0, 1'b0);
        chk_reg("x9_eq22", 9, 22);
        alu_i("xori_x10", 10, 2, 20, ALU_XOR, 1'b1, 1'b0, 1'b0);
        chk_reg("x10_eq22", 10, 22);
        alu_i("andi_x12", 12, 2, 20, ALU_AND, 1'b1, 1'b0, 1'b1);
        chk_reg("x12_eq0", 12, 0);
        alu_r("or_x18", 18, 2, 3, ALU_OR, 1'b1, 1'b0, 1'b0);
        chk_reg("x18_eq3", 18, 3);
        alu_i("srl_neg", 0, 4, 1, ALU_SRL, 1'b0, 1'b0, 1'b0);
        alu_i("sra_neg", 0, 4, 1, ALU_SRA, 1'b0, 1'b1, 1'b0);
        alu_r("op10_zero", 0, 4, 4, 4'd10, 1'b0, 1'b0, 1'b1);
        alu_r("op15_zero", 0, 4, 2, 4'd15, 1'b0, 1'b0, 1'b1);
        alu_i("slli_shamt5", 19, 2, 33, ALU_SLL, 1'b1, 1'b0, 1'b0);
        chk_reg("x19_eq4", 19, 4);
        alu_r("add_wrap", 21, 4, 2, ALU_ADD, 1'b1, 1'b0, 1'b0);
        chk_reg("x21_eq1", 21, 1);

        // stores and loads: x2+20 = 22 -> word 5
        step("sw_x1", s_t(2, 1, 20), ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_reg("x20_kept", 20, 20);
        step("lw_x14", i_t(14, 2, 20, OP_LOAD), ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_reg("x14_eq5", 14, 5);
        step("lw_nord", i_t(15, 2, 20, OP_LOAD), ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_reg("x15_eq0", 15, 0);
        step("lw_wrap", i_t(16, 2, 277, OP_LOAD), ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_reg("x16_eq5", 16, 5);
        // store x3 while reading: old word 5 goes to rd field (= imm[4:0] = x20)
        step("sw_rd_old", s_t(2, 3, 20), ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_reg("x20_old5", 20, 5);
        step("lw_x17", i_t(17, 2, 20, OP_LOAD), ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_reg("x17_eq3", 17, 3);

        // LUI bypasses ALU; encoded rs1 field = x2, rs2 = x0 so XOR gives 2
        step("lui_x22", u_t(22, 20), ALU_XOR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_i("srli_x23", 23, 22, 12, ALU_SRL, 1'b1, 1'b0, 1'b0);
        chk_reg("x23_eq20", 23, 20);
        alu_i("lui_low0", 0, 22, 20, ALU_SLL, 1'b0, 1'b0, 1'b1);

        // x0 ignores writes
        alu_i("addi_x0", 0, 2, 20, ALU_ADD, 1'b1, 1'b0, 1'b0);
        chk_reg("x0_still0", 0, 0);

        // asynchronous reset between edges
        #2 RST_N = 1'b0;
        chk_reg("rst_x1", 1, 1);
        chk_reg("rst_x14", 14, 14);
        chk_reg("rst_x22", 22, 22);
        RST_N = 1'b1;
        step("lw_after_rst", i_t(14, 2, 20, OP_LOAD), ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_reg("dmem_cleared", 14, 0);
        chk_reg("post_rst_x2", 2, 2);

        if (q.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
